// File: rtl/xbar_slv_sram_bridge_pkg.sv
// ============================================================================
//  Module      : xbar_pkg
//  Description : Shared commands, FSM encodings and helpers for the
//                crossbar-slave to SRAM bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package xbar_pkg;

    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

    localparam int          ST_W       = 3;
    localparam logic [2:0]  ST_IDLE    = 3'd0;
    localparam logic [2:0]  ST_ISSUE   = 3'd1;
    localparam logic [2:0]  ST_WAIT    = 3'd2;
    localparam logic [2:0]  ST_ACK     = 3'd3;
    localparam logic [2:0]  ST_ERR     = 3'd4;
    localparam logic [2:0]  ST_RECOVER = 3'd5;

    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/xbar_slv_sram_bridge_if.sv
// ============================================================================
//  Module      : xbar_slv_sram_bridge_if
//  Description : Crossbar slave port plus SRAM port seen by the bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface xbar_slv_sram_bridge_if #(
    parameter int CMD_W = 1,
    parameter int AW    = 12,
    parameter int DW    = 32,
    parameter int SW    = 4,
    parameter int MAW   = 10
);

    logic             iSlvReq;
    logic [CMD_W-1:0] iSlvCmd;
    logic [AW-1:0]    iSlvAddr;
    logic [SW-1:0]    iSlvSel;
    logic [DW-1:0]    iSlvWData;
    logic             oSlvAck;
    logic [DW-1:0]    oSlvRData;
    logic             oMemCe;
    logic             oMemWe;
    logic [MAW-1:0]   oMemAddr;
    logic [SW-1:0]    oMemBe;
    logic [DW-1:0]    oMemWData;
    logic [DW-1:0]    iMemRData;
    logic [7:0]       oErrCnt;

    // The bridge side
    modport slave (
        input  iSlvReq, iSlvCmd, iSlvAddr, iSlvSel, iSlvWData, iMemRData,
        output oSlvAck, oSlvRData, oMemCe, oMemWe, oMemAddr, oMemBe,
               oMemWData, oErrCnt
    );

    // The requester / SRAM environment side
    modport master (
        output iSlvReq, iSlvCmd, iSlvAddr, iSlvSel, iSlvWData, iMemRData,
        input  oSlvAck, oSlvRData, oMemCe, oMemWe, oMemAddr, oMemBe,
               oMemWData, oErrCnt
    );

endinterface

`default_nettype wire

// File: rtl/xbar_slv_sram_bridge.sv
// ============================================================================
//  Module      : xbar_slv_sram_bridge
//  Description : Turns one crossbar slave request into one SRAM access and
//                returns a single-cycle Ack; out-of-range requests error out.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xbar_slv_sram_bridge
    import xbar_pkg::*;
#(
    parameter int              CMD_W      = 1,
    parameter int              AW         = 12,
    parameter int              DW         = 32,
    parameter int              SW         = 4,
    parameter int              MAW        = AW - clog2(SW),
    parameter int              RD_LAT     = 2,
    parameter int              WS         = 1,
    parameter logic [AW-1:0]   ADDR_LIMIT = 12'h400,
    parameter logic [DW-1:0]   ERR_DATA   = DW'(ERR_DATA_DEF)
) (
    input  wire logic             iClk,
    input  wire logic             iRst_n,
    xbar_slv_sram_bridge_if.slave bus
);

    localparam int CNT_W    = 3;
    localparam int ADDR_LSB = clog2(SW);

    typedef enum logic [ST_W-1:0] {
        IDLE    = ST_IDLE,
        ISSUE   = ST_ISSUE,
        WAIT    = ST_WAIT,
        ACK     = ST_ACK,
        ERR     = ST_ERR,
        RECOVER = ST_RECOVER
    } state_t;

    state_t          r_state;
    logic [CNT_W-1:0] r_cnt;
    logic            r_hold_wr;
    logic            r_ack;
    logic [DW-1:0]   r_rdata;
    logic            r_mem_ce;
    logic            r_mem_we;
    logic [MAW-1:0]  r_mem_addr;
    logic [SW-1:0]   r_mem_be;
    logic [DW-1:0]   r_mem_wdata;
    logic [7:0]      r_err_cnt;

    logic            w_in_range;
    logic            w_req_wr;
    logic [CNT_W-1:0] w_load;

    assign w_in_range = (bus.iSlvAddr < ADDR_LIMIT);
    assign w_req_wr   = (bus.iSlvCmd[0] == CMD_WR);
    assign w_load     = r_hold_wr ? CNT_W'(WS) : CNT_W'(RD_LAT);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_hold_wr   <= 1'b0;
            r_ack       <= 1'b0;
            r_rdata     <= '0;
            r_mem_ce    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            r_err_cnt   <= '0;
        end else begin
            // SRAM strobes and Ack are single-cycle; only the transitions
            // below raise them for the following cycle.
            r_ack       <= 1'b0;
            r_mem_ce    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;

            case (r_state)
                IDLE: begin
                    if (bus.iSlvReq) begin
                        r_hold_wr <= w_req_wr;
                        if (w_in_range) begin
                            r_state     <= ISSUE;
                            r_mem_ce    <= 1'b1;
                            r_mem_we    <= w_req_wr;
                            r_mem_addr  <= MAW'(bus.iSlvAddr >> ADDR_LSB);
                            r_mem_be    <= bus.iSlvSel;
                            r_mem_wdata <= bus.iSlvWData;
                        end else begin
                            r_state <= ERR;
                            r_ack   <= 1'b1;
                            if (!w_req_wr) begin
                                r_rdata <= ERR_DATA;
                            end
                            if (r_err_cnt != 8'hFF) begin
                                r_err_cnt <= r_err_cnt + 8'd1;
                            end
                        end
                    end
                end

                ISSUE: begin
                    r_cnt <= w_load;
                    if (w_load != '0) begin
                        r_state <= WAIT;
                    end else begin
                        r_state <= ACK;
                        r_ack   <= 1'b1;
                        if (!r_hold_wr) begin
                            r_rdata <= bus.iMemRData;
                        end
                    end
                end

                WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    // Leaving WAIT coincides with the cycle the SRAM data is valid.
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ACK;
                        r_ack   <= 1'b1;
                        if (!r_hold_wr) begin
                            r_rdata <= bus.iMemRData;
                        end
                    end
                end

                ACK:     r_state <= RECOVER;
                ERR:     r_state <= RECOVER;
                RECOVER: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.oSlvAck   = r_ack;
    assign bus.oSlvRData = r_rdata;
    assign bus.oMemCe    = r_mem_ce;
    assign bus.oMemWe    = r_mem_we;
    assign bus.oMemAddr  = r_mem_addr;
    assign bus.oMemBe    = r_mem_be;
    assign bus.oMemWData = r_mem_wdata;
    assign bus.oErrCnt   = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_xbar_slv_sram_bridge.sv
// ============================================================================
//  Module      : tb_xbar_slv_sram_bridge
//  Description : Self-checking bench for the crossbar-slave to SRAM bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xbar_slv_sram_bridge;

    localparam int          RD_LAT   = 2;
    localparam int          WS       = 1;
    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

    logic clk;
    logic rst_n;

    xbar_slv_sram_bridge_if #(.CMD_W(1), .AW(12), .DW(32), .SW(4), .MAW(10)) bus ();

    xbar_slv_sram_bridge #(
        .CMD_W(1), .AW(12), .DW(32), .SW(4), .MAW(10),
        .RD_LAT(RD_LAT), .WS(WS), .ADDR_LIMIT(12'h400), .ERR_DATA(ERR_WORD)
    ) dut (
        .iClk  (clk),
        .iRst_n(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM environment: byte-masked writes, RD_LAT-cycle read pipeline,
    // garbage on the data bus whenever no read is in flight.
    logic [31:0] sram [1024];
    logic [31:0] rd_pipe [RD_LAT];
    logic        mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) sram[i] <= 32'h0;
            mem_init <= 1'b1;
        end else if (bus.oMemCe && bus.oMemWe) begin
            for (int b = 0; b < 4; b++)
                if (bus.oMemBe[b]) sram[bus.oMemAddr][8*b +: 8] <= bus.oMemWData[8*b +: 8];
        end
        rd_pipe[0] <= (bus.oMemCe && !bus.oMemWe) ? sram[bus.oMemAddr] : $urandom;
        for (int s = 1; s < RD_LAT; s++) rd_pipe[s] <= rd_pipe[s-1];
    end
    assign bus.iMemRData = rd_pipe[RD_LAT-1];

    // Reference model state
    logic [31:0] ref_mem [1024];
    logic [31:0] exp_hold;
    int          exp_err;
    int          n_checks;
    int          n_fail;

    // Drives one request and observes the bus cycle by cycle (cycle 0 = request).
    task automatic do_access(input logic wr, input logic [11:0] addr, input logic [3:0] sel,
                             input logic [31:0] wdata, output int ack_cyc, output int n_ack,
                             output logic [31:0] rd, output int n_ce, output logic ce_we,
                             output logic [9:0] ce_addr, output logic [3:0] ce_be,
                             output logic [31:0] ce_wdata);
        ack_cyc = -1; n_ack = 0; rd = '0; n_ce = 0;
        ce_we = 1'b0; ce_addr = '0; ce_be = '0; ce_wdata = '0;
        @(negedge clk);
        bus.iSlvReq   = 1'b1;
        bus.iSlvCmd   = wr;
        bus.iSlvAddr  = addr;
        bus.iSlvSel   = sel;
        bus.iSlvWData = wdata;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.oMemCe) begin
                n_ce++;
                ce_we = bus.oMemWe; ce_addr = bus.oMemAddr;
                ce_be = bus.oMemBe; ce_wdata = bus.oMemWData;
            end
            if (bus.oSlvAck) begin
                n_ack++;
                if (ack_cyc < 0) begin
                    ack_cyc = k;
                    rd = bus.oSlvRData;
                end
                bus.iSlvReq = 1'b0;
            end
            if (k == 1) begin
                bus.iSlvCmd   = 1'($urandom);
                bus.iSlvAddr  = 12'($urandom);
                bus.iSlvSel   = 4'($urandom);
                bus.iSlvWData = $urandom;
            end
            if (ack_cyc >= 0 && k >= ack_cyc + 2) break;
        end
        bus.iSlvReq = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.oSlvAck, bus.oMemCe, bus.oMemWe} !== 3'b000) begin
            n_fail++; $display("FAIL reset_strobes: got %b expected 000", {bus.oSlvAck, bus.oMemCe, bus.oMemWe});
        end
        n_checks++;
        if ({bus.oSlvRData, bus.oMemWData, bus.oMemAddr, bus.oMemBe, bus.oErrCnt} !== 86'h0) begin
            n_fail++; $display("FAIL reset_buses: rdata %h wdata %h addr %h be %h errcnt %h expected all 0",
                               bus.oSlvRData, bus.oMemWData, bus.oMemAddr, bus.oMemBe, bus.oErrCnt);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_write();
        int ac, na, nc; logic [31:0] rd, cw; logic we; logic [9:0] ca; logic [3:0] cb;
        do_access(1'b1, 12'h010, 4'hF, 32'h1234_5678, ac, na, rd, nc, we, ca, cb, cw);
        for (int b = 0; b < 4; b++) ref_mem[4][8*b +: 8] = cw[8*b +: 8] & 8'h00 | 8'(32'h1234_5678 >> (8*b));
        n_checks++;
        if (ac !== 3 || na !== 1) begin
            n_fail++; $display("FAIL write_ack: cycle %0d count %0d expected cycle 3 count 1", ac, na);
        end
        n_checks++;
        if (nc !== 1 || we !== 1'b1 || ca !== 10'h004 || cb !== 4'hF || cw !== 32'h1234_5678) begin
            n_fail++; $display("FAIL write_sram: ce %0d we %b addr %h be %h wdata %h expected 1 1 004 f 12345678",
                               nc, we, ca, cb, cw);
        end
        n_checks++;
        if (rd !== exp_hold) begin
            n_fail++; $display("FAIL write_rdata_held: got %h expected %h", rd, exp_hold);
        end
    endtask

    task automatic test_read_back();
        int ac, na, nc; logic [31:0] rd, cw; logic we; logic [9:0] ca; logic [3:0] cb;
        do_access(1'b0, 12'h010, 4'hF, 32'h0, ac, na, rd, nc, we, ca, cb, cw);
        exp_hold = 32'h1234_5678;
        n_checks++;
        if (ac !== 4 || na !== 1 || rd !== 32'h1234_5678) begin
            n_fail++; $display("FAIL read_back: ack cycle %0d count %0d data %h expected 4 1 12345678", ac, na, rd);
        end
        n_checks++;
        if (nc !== 1 || we !== 1'b0 || ca !== 10'h004) begin
            n_fail++; $display("FAIL read_sram: ce %0d we %b addr %h expected 1 0 004", nc, we, ca);
        end
    endtask

    task automatic test_partial_write();
        int ac, na, nc; logic [31:0] rd, cw; logic we; logic [9:0] ca; logic [3:0] cb;
        do_access(1'b1, 12'h010, 4'b0101, 32'hAABB_CCDD, ac, na, rd, nc, we, ca, cb, cw);
        ref_mem[4] = 32'h12BB_56DD;
        n_checks++;
        if (cb !== 4'b0101 || ac !== 3) begin
            n_fail++; $display("FAIL partial_be: be %b ack %0d expected 0101 3", cb, ac);
        end
        do_access(1'b0, 12'h012, 4'h0, 32'h0, ac, na, rd, nc, we, ca, cb, cw);
        exp_hold = 32'h12BB_56DD;
        n_checks++;
        if (rd !== 32'h12BB_56DD || ac !== 4) begin
            n_fail++; $display("FAIL partial_readback: got %h at cycle %0d expected 12bb56dd at 4", rd, ac);
        end
    endtask

    task automatic test_out_of_range();
        int ac, na, nc; logic [31:0] rd, cw; logic we; logic [9:0] ca; logic [3:0] cb;
        do_access(1'b0, 12'h400, 4'hF, 32'h0, ac, na, rd, nc, we, ca, cb, cw);
        exp_err = exp_err + 1;
        exp_hold = ERR_WORD;
        n_checks++;
        if (ac !== 1 || na !== 1 || rd !== ERR_WORD || nc !== 0) begin
            n_fail++; $display("FAIL oor_read: ack %0d count %0d data %h ce %0d expected 1 1 deadbeef 0", ac, na, rd, nc);
        end
        n_checks++;
        if (bus.oErrCnt !== 8'(exp_err)) begin
            n_fail++; $display("FAIL oor_errcnt: got %0d expected %0d", bus.oErrCnt, exp_err);
        end
        do_access(1'b1, 12'hFFC, 4'hF, 32'h5555_AAAA, ac, na, rd, nc, we, ca, cb, cw);
        exp_err = exp_err + 1;
        n_checks++;
        if (ac !== 1 || rd !== exp_hold || nc !== 0 || bus.oErrCnt !== 8'(exp_err)) begin
            n_fail++; $display("FAIL oor_write: ack %0d data %h ce %0d errcnt %0d expected 1 %h 0 %0d",
                               ac, rd, nc, bus.oErrCnt, exp_hold, exp_err);
        end
    endtask

    task automatic test_req_held();
        int acks[$]; int nc; logic [31:0] rds[$];
        nc = 0;
        @(negedge clk);
        bus.iSlvReq = 1'b1; bus.iSlvCmd = 1'b0; bus.iSlvAddr = 12'h010;
        bus.iSlvSel = 4'hF; bus.iSlvWData = 32'h0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (bus.oMemCe) nc++;
            if (bus.oSlvAck) begin
                acks.push_back(k); rds.push_back(bus.oSlvRData);
                if (acks.size() >= 2) bus.iSlvReq = 1'b0;
            end
        end
        bus.iSlvReq = 1'b0;
        // Ack at 2+RD_LAT, one RECOVER cycle, accept again 2 cycles after Ack
        n_checks++;
        if (acks.size() !== 2 || nc !== 2) begin
            n_fail++; $display("FAIL held_count: acks %0d ce %0d expected 2 2", acks.size(), nc);
        end else begin
            n_checks++;
            if (acks[0] !== 2 + RD_LAT || acks[1] !== 2 * (2 + RD_LAT) + 2) begin
                n_fail++; $display("FAIL held_timing: acks at %0d %0d expected %0d %0d",
                                   acks[0], acks[1], 2 + RD_LAT, 2 * (2 + RD_LAT) + 2);
            end
            n_checks++;
            if (rds[0] !== ref_mem[4] || rds[1] !== ref_mem[4]) begin
                n_fail++; $display("FAIL held_data: got %h %h expected %h", rds[0], rds[1], ref_mem[4]);
            end
        end
        exp_hold = ref_mem[4];
    endtask

    task automatic test_random();
        int ac, na, nc, exp_lat; logic [31:0] rd, cw, wdata, exp_rd; logic we, wr, err;
        logic [9:0] ca; logic [3:0] cb, sel; logic [11:0] addr;
        for (int i = 0; i < 80; i++) begin
            wr    = 1'($urandom);
            addr  = ($urandom_range(0, 3) == 0) ? 12'(12'h3F0 + $urandom_range(0, 31))
                                                : 12'($urandom_range(0, 63));
            sel   = 4'($urandom);
            wdata = $urandom;
            err   = (addr >= 12'h400);
            exp_lat = err ? 1 : (wr ? 2 + WS : 2 + RD_LAT);
            if (err) exp_rd = wr ? exp_hold : ERR_WORD;
            else     exp_rd = wr ? exp_hold : ref_mem[addr[11:2]];
            do_access(wr, addr, sel, wdata, ac, na, rd, nc, we, ca, cb, cw);
            if (!err && wr)
                for (int b = 0; b < 4; b++) if (sel[b]) ref_mem[addr[11:2]][8*b +: 8] = wdata[8*b +: 8];
            if (err && exp_err < 255) exp_err++;
            exp_hold = exp_rd;
            n_checks++;
            if (ac !== exp_lat || na !== 1 || rd !== exp_rd) begin
                n_fail++; $display("FAIL rand_ack[%0d]: cycle %0d count %0d data %h expected %0d 1 %h",
                                   i, ac, na, rd, exp_lat, exp_rd);
            end
            n_checks++;
            if (nc !== (err ? 0 : 1) || bus.oErrCnt !== 8'(exp_err)) begin
                n_fail++; $display("FAIL rand_ce_err[%0d]: ce %0d errcnt %0d expected %0d %0d",
                                   i, nc, bus.oErrCnt, err ? 0 : 1, exp_err);
            end
            if (!err) begin
                n_checks++;
                if (we !== wr || ca !== addr[11:2] || cb !== sel || cw !== wdata) begin
                    n_fail++; $display("FAIL rand_sram[%0d]: we %b addr %h be %h wdata %h expected %b %h %h %h",
                                       i, we, ca, cb, cw, wr, addr[11:2], sel, wdata);
                end
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_err_saturate();
        int ac, na, nc; logic [31:0] rd, cw; logic we; logic [9:0] ca; logic [3:0] cb;
        for (int i = 0; i < 260; i++) begin
            do_access(1'b0, 12'(12'h400 + $urandom_range(0, 12'hBFF)), 4'hF, 32'h0,
                      ac, na, rd, nc, we, ca, cb, cw);
            if (exp_err < 255) exp_err++;
        end
        exp_hold = ERR_WORD;
        n_checks++;
        if (bus.oErrCnt !== 8'hFF || exp_err !== 255) begin
            n_fail++; $display("FAIL err_saturate: got %h expected ff", bus.oErrCnt);
        end
        n_checks++;
        if (rd !== ERR_WORD || ac !== 1) begin
            n_fail++; $display("FAIL err_last: data %h cycle %0d expected deadbeef 1", rd, ac);
        end
    endtask

    task automatic test_mid_reset();
        int ac, na, nc, stray; logic [31:0] rd, cw; logic we; logic [9:0] ca; logic [3:0] cb;
        stray = 0;
        @(negedge clk);
        bus.iSlvReq = 1'b1; bus.iSlvCmd = 1'b0; bus.iSlvAddr = 12'h010;
        bus.iSlvSel = 4'hF; bus.iSlvWData = 32'h0;
        @(negedge clk);
        n_checks++;
        if (bus.oMemCe !== 1'b1) begin
            n_fail++; $display("FAIL midrst_issue: ce %b expected 1", bus.oMemCe);
        end
        @(negedge clk);
        rst_n = 1'b0;
        bus.iSlvReq = 1'b0;
        #1;
        n_checks++;
        if ({bus.oSlvAck, bus.oMemCe, bus.oMemWe, bus.oErrCnt, bus.oSlvRData} !== 43'h0) begin
            n_fail++; $display("FAIL midrst_outputs: ack %b ce %b we %b errcnt %h rdata %h expected all 0",
                               bus.oSlvAck, bus.oMemCe, bus.oMemWe, bus.oErrCnt, bus.oSlvRData);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_err = 0;
        exp_hold = 32'h0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.oSlvAck || bus.oMemCe) stray++;
        end
        n_checks++;
        if (stray !== 0) begin
            n_fail++; $display("FAIL midrst_stray: %0d ack/ce cycles expected 0", stray);
        end
        do_access(1'b0, 12'h010, 4'hF, 32'h0, ac, na, rd, nc, we, ca, cb, cw);
        n_checks++;
        if (ac !== 4 || na !== 1 || nc !== 1 || rd !== ref_mem[4]) begin
            n_fail++; $display("FAIL midrst_next_read: ack %0d count %0d ce %0d data %h expected 4 1 1 %h",
                               ac, na, nc, rd, ref_mem[4]);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_hold = 32'h0;
        exp_err  = 0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        rst_n         = 1'b0;
        bus.iSlvReq   = 1'b0;
        bus.iSlvCmd   = 1'b0;
        bus.iSlvAddr  = 12'h0;
        bus.iSlvSel   = 4'h0;
        bus.iSlvWData = 32'h0;

        test_reset();
        test_write();
        test_read_back();
        test_partial_write();
        test_out_of_range();
        test_req_held();
        test_random();
        test_err_saturate();
        test_mid_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/xbar_slv_sram_bridge.md
Name: xbar_slv_sram_bridge

Overview:
- Downstream endpoint of one crossbar slave port.
- Consumes the arbitrated request (Req/Cmd/Addr/Sel/WData) and returns a single-cycle Ack with RData.
- Converts each request into one access on a synchronous single-port SRAM with fixed read latency and programmable write wait states.
- Out-of-range addresses complete with an error pattern, without touching the SRAM.

Parameters:
- CMD_W, 1: command width; bit0 = 1 means write, 0 means read.
- AW, 12: byte address width.
- DW, 32: data width.
- SW, 4: byte-select width, equal to DW/8.
- MAW, 10: SRAM word address width, equal to AW - log2(SW).
- RD_LAT, 2: SRAM read latency in cycles, legal range 1..4.
- WS, 1: write wait states, legal range 0..3.
- ADDR_LIMIT, 12'h400: first illegal byte address; an access is legal when iSlvAddr < ADDR_LIMIT.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on an error access.

Ports:
- iClk, in, 1: clock.
- iRst_n, in, 1: reset, asynchronous, active-low.
- iSlvReq, in, 1: request level, held high until Ack.
- iSlvCmd, in, CMD_W: read/write command.
- iSlvAddr, in, AW: byte address.
- iSlvSel, in, SW: byte enables.
- iSlvWData, in, DW: write data.
- oSlvAck, out, 1: one-cycle completion pulse.
- oSlvRData, out, DW: registered read data.
- oMemCe, out, 1: SRAM chip enable.
- oMemWe, out, 1: SRAM write enable.
- oMemAddr, out, MAW: SRAM word address, taken from iSlvAddr[AW-1:log2(SW)].
- oMemBe, out, SW: SRAM byte enables.
- oMemWData, out, DW: SRAM write data.
- iMemRData, in, DW: SRAM read data.
- oErrCnt, out, 8: count of error accesses, saturates at 8'hFF.

Behaviour:
- Clock/reset: one clock, iClk. Reset iRst_n is asynchronous and active-low. All outputs are registered and reset to 0; FSM resets to IDLE; the wait counter resets to 0.
- FSM states: IDLE, ISSUE, WAIT, ACK, ERR, RECOVER.
- IDLE, iSlvReq=1 seen in cycle 0:
  - Cmd, Addr, Sel and WData are captured into holding registers.
  - Inputs after capture are ignored until the next IDLE.
  - Next state is ERR if the address is out of range, otherwise ISSUE.
- ISSUE (cycle 1):
  - oMemCe=1, oMemAddr, oMemBe and oMemWData driven from the holding registers.
  - oMemWe = captured Cmd bit0. A write with Sel=0 still issues, with oMemBe=0.
  - Wait counter loads RD_LAT for a read, or WS for a write.
  - Next state is WAIT if the loaded value is nonzero, otherwise ACK.
  - All oMem* outputs are 0 in every state other than ISSUE.
- WAIT: counter decrements each cycle; the state exits to ACK when the counter reaches 1.
- Read data capture: iMemRData is valid in cycle 1+RD_LAT and is sampled at the end of that cycle into oSlvRData.
- Read timing: oSlvAck=1 in cycle 2+RD_LAT, with oSlvRData valid in that same cycle.
- Write timing: oSlvAck=1 in cycle 2+WS. oSlvRData is unchanged by a write.
- oSlvRData holding: the value is held until the next read or error-read Ack.
- ERR state (cycle 1):
  - oSlvAck=1; no SRAM access is made.
  - oErrCnt increments unless it is at 8'hFF.
  - For a read, oSlvRData = ERR_DATA; for a write, oSlvRData is unchanged.
- ACK and ERR both advance to RECOVER.
- RECOVER: exactly one cycle in which iSlvReq is ignored, because a requester may still hold Req high in the cycle after Ack. RECOVER then goes to IDLE.
- Back-to-back rate: a new request is accepted no earlier than 2 cycles after Ack.
- oSlvAck is never high for 2 consecutive cycles.
- Dropped request: if iSlvReq falls after capture, the access still completes and acks. No abort is supported.
- Mid-operation reset: the in-flight access is discarded, oMemCe drops immediately, and no Ack is produced.
- Address width: the word address uses the upper AW-log2(SW) bits. The low address bits are ignored and no alignment check is made.

Decomposition:
- Package xbar_pkg holds:
  - CMD_RD=0 and CMD_WR=1;
  - the FSM state encodings (3-bit localparams);
  - the ERR_DATA default;
  - a clog2 function used to derive MAW.
- No sub-module: the FSM, wait counter and error counter live in one file of roughly 200 lines.

Test Plan:
All scenarios use the defaults (RD_LAT=2, WS=1).
- Write: Req, Cmd=1, Addr=12'h010, Sel=4'hF, WData=32'h1234_5678 in cycle 0 -> oMemCe=oMemWe=1 with oMemAddr=10'h004 in cycle 1; oSlvAck in cycle 3 only.
- Read-back: read Addr=12'h010 -> oMemCe in cycle 1, oMemWe=0; oSlvAck in cycle 4 with oSlvRData=32'h1234_5678.
- Partial write: write Sel=4'b0101, WData=32'hAABB_CCDD over 32'h1234_5678 -> oMemBe=4'b0101; read-back gives 32'h12BB_56DD.
- Out-of-range read: Addr=12'h400 -> no oMemCe; oSlvAck in cycle 1 with oSlvRData=32'hDEAD_BEEF; oErrCnt=1. After 256 such errors, oErrCnt=8'hFF.
- Req held high: keep iSlvReq=1 continuously across 2 reads -> Acks at least 2 cycles apart; exactly 2 oMemCe pulses, no duplicate access.
- Mid-operation reset: assert iRst_n=0 in cycle 2 of a read -> all outputs 0 immediately; no Ack after release; the next read completes normally with 4-cycle latency.
